// File: rtl/signal_cu.sv
// Traffic signal controller: GREEN -> YELLOW -> RED cycle timed in prescaled ticks, with a pedestrian walk light.
// Optional pedestrian blink window at the end of RED is enabled by defining SIGNAL_CU_PED_BLINK_EN.
module signal_cu #(
    parameter int TICK_DIV        = 10,
    parameter int PED_BLINK_TICKS = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] traffic_sel,
    output logic [1:0] o_tr_state,
    output logic       o_tr_light,
    output logic       tr_valid,
    output logic       light_valid
);

    typedef enum logic [1:0] {
        GREEN  = 2'b00,
        YELLOW = 2'b01,
        RED    = 2'b10
    } phase_t;

    typedef enum logic [1:0] {
        MODE_NORMAL = 2'b00,
        MODE_LOW    = 2'b01,
        MODE_HEAVY  = 2'b10
    } mode_t;

    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    if (TICK_DIV < 2 || PED_BLINK_TICKS < 1 || PED_BLINK_TICKS > 10) begin : g_bad_params
        $error("signal_cu: TICK_DIV must be >= 2 and PED_BLINK_TICKS within 1..10");
    end

    phase_t        phase_q, phase_d;
    mode_t         mode_q, mode_d;
    logic [PW-1:0] presc_q, presc_d;
    logic [4:0]    cnt_q, cnt_d;
    logic          light_q, light_d;
    logic          tr_valid_q, tr_valid_d;
    logic          light_valid_q, light_valid_d;
    logic          tick;
`ifdef SIGNAL_CU_PED_BLINK_EN
    logic [4:0]    win_start;
`endif

    function automatic logic [4:0] phase_ticks(input phase_t ph, input mode_t md);
        logic [4:0] g;
        logic [4:0] r;
        case (md)
            MODE_LOW:   begin g = 5'd10; r = 5'd25; end
            MODE_HEAVY: begin g = 5'd30; r = 5'd10; end
            default:    begin g = 5'd20; r = 5'd15; end
        endcase
        case (ph)
            GREEN:   return g;
            YELLOW:  return 5'd3;
            default: return r;
        endcase
    endfunction

    assign tick = (presc_q == PW'(TICK_DIV - 1));

    // tr_valid / light_valid are single-cycle strobes, high only in the first cycle a changed output is visible.
    always_comb begin
        presc_d = tick ? '0 : presc_q + PW'(1);
        phase_d = phase_q;
        mode_d  = mode_q;
        cnt_d   = cnt_q;
        if (tick) begin
            if (cnt_q == phase_ticks(phase_q, mode_q) - 5'd1) begin
                cnt_d = '0;
                case (phase_q)
                    GREEN:   phase_d = YELLOW;
                    YELLOW:  phase_d = RED;
                    default: phase_d = GREEN;
                endcase
                // Mode is sampled only when a new cycle begins; code 11 behaves as normal.
                if (phase_d == GREEN) begin
                    mode_d = (traffic_sel == 2'b11) ? MODE_NORMAL : mode_t'(traffic_sel);
                end
            end else begin
                cnt_d = cnt_q + 5'd1;
            end
        end

`ifdef SIGNAL_CU_PED_BLINK_EN
        // Window tick k shows 0 for even k, 1 for odd k: parity of (cnt - start) is the LSB xor.
        win_start = phase_ticks(RED, mode_d) - 5'(PED_BLINK_TICKS);
        light_d   = (phase_d == RED) && ((cnt_d < win_start) || (cnt_d[0] ^ win_start[0]));
`else
        light_d   = (phase_d == RED);
`endif

        tr_valid_d    = (phase_d != phase_q);
        light_valid_d = (light_d != light_q);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            phase_q       <= GREEN;
            mode_q        <= MODE_NORMAL;
            presc_q       <= '0;
            cnt_q         <= '0;
            light_q       <= 1'b0;
            tr_valid_q    <= 1'b0;
            light_valid_q <= 1'b0;
        end else begin
            phase_q       <= phase_d;
            mode_q        <= mode_d;
            presc_q       <= presc_d;
            cnt_q         <= cnt_d;
            light_q       <= light_d;
            tr_valid_q    <= tr_valid_d;
            light_valid_q <= light_valid_d;
        end
    end

    assign o_tr_state  = phase_q;
    assign o_tr_light  = light_q;
    assign tr_valid    = tr_valid_q;
    assign light_valid = light_valid_q;

endmodule

// File: tb/tb_signal_cu.sv
// Self-checking bench for signal_cu: directed phase-length table, reset-in-RED sequence,
// and randomized traffic_sel/reset traffic checked every cycle against a cycle-countdown model.
module tb_signal_cu;

    localparam int TD = 10;
    localparam int PB = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [1:0] traffic_sel = 2'bxx;
    logic [1:0] o_tr_state;
    logic       o_tr_light;
    logic       tr_valid;
    logic       light_valid;

    int checks = 0;
    int failures = 0;

    signal_cu #(.TICK_DIV(TD), .PED_BLINK_TICKS(PB)) dut (
        .clk         (clk),
        .reset       (reset),
        .traffic_sel (traffic_sel),
        .o_tr_state  (o_tr_state),
        .o_tr_light  (o_tr_light),
        .tr_valid    (tr_valid),
        .light_valid (light_valid)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d t=%0t", name, act, exp, $time);
        end
    endtask

    // Phase lengths in ticks, indexed by phase (0 G, 1 Y, 2 R) and mode (0 normal, 1 low, 2 heavy).
    function automatic int ticks_of(input int ph, input int md);
        int g;
        int r;
        case (md)
            1:       begin g = 10; r = 25; end
            2:       begin g = 30; r = 10; end
            default: begin g = 20; r = 15; end
        endcase
        if (ph == 0) return g;
        if (ph == 1) return 3;
        return r;
    endfunction

    // Reference model: remaining cycles in the current phase, counted down once per edge.
    int         m_phase, m_mode, m_rem, m_light, m_tv, m_lv;
    logic       cap_r;
    logic [1:0] cap_s;

    always begin
        int prev_light;
        int idx;
        int ws;
        @(posedge clk);
        cap_r = reset;
        cap_s = traffic_sel;
        #1;
        if (cap_r) begin
            m_phase = 0;
            m_mode  = 0;
            m_rem   = ticks_of(0, 0) * TD;
            m_light = 0;
            m_tv    = 0;
            m_lv    = 0;
        end else begin
            prev_light = m_light;
            m_rem--;
            m_tv = 0;
            if (m_rem == 0) begin
                m_phase = (m_phase + 1) % 3;
                if (m_phase == 0) m_mode = (cap_s == 2'b11) ? 0 : int'(cap_s);
                m_rem = ticks_of(m_phase, m_mode) * TD;
                m_tv  = 1;
            end
            if (m_phase == 2) begin
`ifdef SIGNAL_CU_PED_BLINK_EN
                idx = (ticks_of(2, m_mode) * TD - m_rem) / TD;
                ws  = ticks_of(2, m_mode) - PB;
                m_light = (idx < ws) ? 1 : ((idx - ws) % 2);
`else
                idx = 0;
                ws  = 0;
                m_light = 1;
`endif
            end else begin
                m_light = 0;
            end
            m_lv = (m_light != prev_light) ? 1 : 0;
        end
        chk("mdl_state", int'(o_tr_state), m_phase);
        chk("mdl_light", int'(o_tr_light), m_light);
        chk("mdl_tr_valid", int'(tr_valid), m_tv);
        chk("mdl_light_valid", int'(light_valid), m_lv);
    end

    // Counts edges until the next tr_valid; applies new_sel once set_at cycles into the phase.
    task automatic measure(input int set_at, input logic [1:0] new_sel, output int n);
        n = 0;
        while (n < 2000) begin
            @(posedge clk);
            #1;
            n++;
            if (tr_valid) break;
            if (n == set_at) traffic_sel = new_sel;
        end
    endtask

    typedef struct {
        logic [1:0] sel;
        logic [1:0] exp_state;
        int         exp_len;
        logic       exp_light;
        logic       exp_tv;
        logic       exp_lv;
    } vec_t;

    vec_t tbl[12];

    initial begin
        int n;
        int hold;

        tbl[0]  = '{2'b01, 2'b00, 200, 1'b0, 1'b0, 1'b0};
        tbl[1]  = '{2'b01, 2'b01, 30,  1'b0, 1'b1, 1'b0};
        tbl[2]  = '{2'b01, 2'b10, 150, 1'b1, 1'b1, 1'b1};
        tbl[3]  = '{2'b10, 2'b00, 100, 1'b0, 1'b1, 1'b1};
        tbl[4]  = '{2'b10, 2'b01, 30,  1'b0, 1'b1, 1'b0};
        tbl[5]  = '{2'b10, 2'b10, 250, 1'b1, 1'b1, 1'b1};
        tbl[6]  = '{2'b11, 2'b00, 300, 1'b0, 1'b1, 1'b1};
        tbl[7]  = '{2'b11, 2'b01, 30,  1'b0, 1'b1, 1'b0};
        tbl[8]  = '{2'b11, 2'b10, 100, 1'b1, 1'b1, 1'b1};
        tbl[9]  = '{2'b11, 2'b00, 200, 1'b0, 1'b1, 1'b1};
        tbl[10] = '{2'b11, 2'b01, 30,  1'b0, 1'b1, 1'b0};
        tbl[11] = '{2'b11, 2'b10, 150, 1'b1, 1'b1, 1'b1};

        // Reset for two edges with traffic_sel undriven.
        repeat (2) @(posedge clk);
        #1;
        chk("rst_state", int'(o_tr_state), 0);
        chk("rst_light", int'(o_tr_light), 0);
        chk("rst_tr_valid", int'(tr_valid), 0);
        chk("rst_light_valid", int'(light_valid), 0);
        reset = 1'b0;
        traffic_sel = 2'b00;

        for (int i = 0; i < 12; i++) begin
            chk($sformatf("v%0d_state", i), int'(o_tr_state), int'(tbl[i].exp_state));
            chk($sformatf("v%0d_light", i), int'(o_tr_light), int'(tbl[i].exp_light));
            chk($sformatf("v%0d_tr_valid", i), int'(tr_valid), int'(tbl[i].exp_tv));
            chk($sformatf("v%0d_light_valid", i), int'(light_valid), int'(tbl[i].exp_lv));
            measure(5, tbl[i].sel, n);
            chk($sformatf("v%0d_len", i), n, tbl[i].exp_len);
        end

        // Reset pulse in the middle of RED.
        n = 0;
        while (o_tr_state != 2'b10 && n < 1000) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("red_reached", int'(o_tr_state), 2);
        repeat (20) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        chk("midrst_state", int'(o_tr_state), 0);
        chk("midrst_light", int'(o_tr_light), 0);
        chk("midrst_tr_valid", int'(tr_valid), 0);
        chk("midrst_light_valid", int'(light_valid), 0);
        measure(0, 2'b00, n);
        chk("midrst_green_len", n, 200);

        // Randomized mode changes and occasional reset pulses, checked by the model.
        hold = 0;
        for (int c = 0; c < 3000; c++) begin
            @(posedge clk);
            #1;
            if (hold > 0) begin
                hold--;
                if (hold == 0) reset = 1'b0;
            end else if ($urandom_range(0, 699) == 0) begin
                reset = 1'b1;
                hold = $urandom_range(1, 2);
            end
            if ($urandom_range(0, 59) == 0) traffic_sel = 2'($urandom_range(0, 3));
        end
        reset = 1'b0;
        repeat (5) @(posedge clk);
        #2;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
